tick_receiver: RTL and testbench

Receive-side companion to the design's clock divider. Takes the four divided, free-running square-wave tick signals (adjust, regular, fast, blink) as plain inputs and converts each rising edge into a single-cycle enable in the 100 MHz `clk` domain, so downstream game logic stays on one clock. Each channel also has a watchdog that flags a stalled tick source. Measured-period capture is optional. Sits between the divider and every consumer of slow timing: game FSM, display blink, input repeat.

---
 rtl/tick_receiver.sv | 108 ++++++++++
 tb/tb_tick_receiver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_receiver.sv
// tick_receiver: turns free-running divided tick square waves into one-cycle clk-domain
// enables, with per-channel stall watchdog. Optional period readout: TICK_PERIOD_CAPTURE_EN.
module tick_receiver #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 120_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   tick_in,
    output logic [NCH-1:0]   tick_en,
    output logic [NCH-1:0]   stall
`ifdef TICK_PERIOD_CAPTURE_EN
    ,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] period,
    output logic             period_vld
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(TIMEOUT - 1);

    logic [NCH-1:0]   s1, s2, p, edge_det;
    logic [1:0]       warm;
    logic             primed;
    logic [CNT_W-1:0] cnt [NCH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    // Until the synchronizer has filled, p tracks s2's source so a level that is
    // already high at reset release is absorbed instead of reported as an edge.
    assign primed = (warm == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm <= 2'd0;
        end else if (!primed) begin
            warm <= warm + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            p       <= '0;
            tick_en <= '0;
        end else begin
            s1      <= tick_in;
            s2      <= s1;
            p       <= primed ? s2 : s1;
            tick_en <= edge_det;
        end
    end

    assign edge_det = s2 & ~p;

    // An edge on the timeout cycle wins: counter and stall both clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (edge_det[i]) begin
                    cnt[i]   <= '0;
                    stall[i] <= 1'b0;
                end else begin
                    cnt[i] <= sat_inc(cnt[i]);
                    if (cnt[i] == STALL_AT) stall[i] <= 1'b1;
                end
            end
        end
    end

`ifdef TICK_PERIOD_CAPTURE_EN
    logic [CNT_W-1:0] per_q [NCH];
    logic [CNT_W-1:0] per_d [NCH];
    logic [NCH-1:0]   seen, vld_q, vld_d;

    // Readout mux looks at next-state values so period lands with tick_en.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            per_d[i] = edge_det[i] ? sat_inc(cnt[i]) : per_q[i];
        end
        vld_d = vld_q | (edge_det & seen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= '0;
            vld_q      <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            for (int i = 0; i < NCH; i++) per_q[i] <= '0;
        end else begin
            seen       <= seen | edge_det;
            vld_q      <= vld_d;
            period     <= per_d[sel];
            period_vld <= vld_d[sel];
            for (int i = 0; i < NCH; i++) per_q[i] <= per_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_tick_receiver.sv
// Self-checking bench for tick_receiver (CNT_W=8, TIMEOUT=100); works with or
// without TICK_PERIOD_CAPTURE_EN.
module tb_tick_receiver;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tick_in = 4'h0;
    logic [1:0] sel = 2'd0;
    logic [3:0] tick_en, stall;
`ifdef TICK_PERIOD_CAPTURE_EN
    logic [7:0] period;
    logic       period_vld;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tick_receiver #(.NCH(4), .CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_in(tick_in),
        .tick_en(tick_en),
        .stall(stall)
`ifdef TICK_PERIOD_CAPTURE_EN
        , .sel(sel), .period(period), .period_vld(period_vld)
`endif
    );

    // Reference model: edge k is the k-th clock after reset release; hist[j] is
    // tick_in as sampled on edge j+1. Reset counts as the last "event" for cnt.
    logic [3:0] hist[$];
    int         k;
    int         last[4];
    int         per_m[4];
    bit         had[4];
    bit         vld_m[4];
    logic [3:0] exp_en, exp_stall;
    logic [7:0] exp_period;
    logic       exp_vld;

    task automatic model_clear();
        hist.delete();
        k = 0;
        for (int c = 0; c < 4; c++) begin
            last[c] = 0; per_m[c] = 0; had[c] = 0; vld_m[c] = 0;
        end
        exp_en = '0; exp_stall = '0; exp_period = '0; exp_vld = 1'b0;
    endtask

    task automatic step();
        logic [3:0] smp, a, b;
        logic [1:0] s;
        bit pulse;
        smp = tick_in;
        s = sel;
        @(posedge clk);
        k++;
        hist.push_back(smp);
        a = (k >= 4) ? hist[k-3] : 4'h0;
        b = (k >= 4) ? hist[k-4] : 4'h0;
        for (int c = 0; c < 4; c++) begin
            pulse = (k >= 4) && a[c] && !b[c];
            if (pulse) begin
                per_m[c] = (k - last[c] > 255) ? 255 : k - last[c];
                if (had[c]) vld_m[c] = 1;
                had[c] = 1;
                last[c] = k;
            end
            exp_en[c]    = pulse;
            exp_stall[c] = (k - last[c] >= TIMEOUT);
        end
        exp_period = 8'(per_m[s]);
        exp_vld    = vld_m[s];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_in = 4'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tick_en !== 4'h0) begin n_bad++; $display("FAIL reset_tick_en: got %b expected 0000", tick_en); end
        n_cmp++; if (stall !== 4'h0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0000", stall); end
`ifdef TICK_PERIOD_CAPTURE_EN
        n_cmp++; if (period !== 8'd0 || period_vld !== 1'b0) begin n_bad++; $display("FAIL reset_period: got %0d/%b expected 0/0", period, period_vld); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        while (k < 8) begin
            step();
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL lat_idle k=%0d: got %b expected %b", k, tick_en, exp_en); end
        end
        tick_in[2] = 1'b1;
        repeat (6) begin
            step();
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL lat_model k=%0d: got %b expected %b", k, tick_en, exp_en); end
            if (k == 10) begin n_cmp++; if (tick_en !== 4'b0000) begin n_bad++; $display("FAIL lat_early: got %b expected 0000", tick_en); end end
            if (k == 11) begin n_cmp++; if (tick_en !== 4'b0100) begin n_bad++; $display("FAIL lat_pulse: got %b expected 0100", tick_en); end end
            if (k == 12) begin n_cmp++; if (tick_en !== 4'b0000) begin n_bad++; $display("FAIL lat_width: got %b expected 0000", tick_en); end end
        end
        tick_in[2] = 1'b0;
    endtask

    task automatic test_periodic();
        int npulse = 0;
        int prev_k = -1;
        sel = 2'd0;
        for (int t = 0; t < 10; t++) begin
            tick_in[0] = ~tick_in[0];
            repeat (20) begin
                step();
                n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL per_tick_en k=%0d: got %b expected %b", k, tick_en, exp_en); end
                n_cmp++; if (stall[0] !== 1'b0) begin n_bad++; $display("FAIL per_stall k=%0d: got %b expected 0", k, stall[0]); end
`ifdef TICK_PERIOD_CAPTURE_EN
                n_cmp++; if (period !== exp_period || period_vld !== exp_vld) begin n_bad++; $display("FAIL per_period k=%0d: got %0d/%b expected %0d/%b", k, period, period_vld, exp_period, exp_vld); end
`endif
                if (tick_en[0] === 1'b1) begin
                    npulse++;
                    if (prev_k >= 0) begin n_cmp++; if (k - prev_k != 40) begin n_bad++; $display("FAIL per_spacing: got %0d expected 40", k - prev_k); end end
                    prev_k = k;
`ifdef TICK_PERIOD_CAPTURE_EN
                    if (npulse == 2) begin n_cmp++; if (period !== 8'd40 || period_vld !== 1'b1) begin n_bad++; $display("FAIL per_second: got %0d/%b expected 40/1", period, period_vld); end end
`endif
                end
            end
        end
        n_cmp++; if (npulse != 5) begin n_bad++; $display("FAIL per_count: got %0d expected 5", npulse); end
    endtask

    task automatic test_stall();
        int kp = -1;
        tick_in[1] = 1'b1;
        for (int j = 0; j < 8 && kp < 0; j++) begin
            step();
            if (tick_en[1] === 1'b1) kp = k;
        end
        n_cmp++; if (kp < 0) begin n_bad++; $display("FAIL stall_first_pulse: got none expected pulse within 8"); return; end
        tick_in[1] = 1'b0;
        while (k < kp + 101) begin
            step();
            n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL stall_model k=%0d: got %b expected %b", k, stall, exp_stall); end
            if (k == kp + 99)  begin n_cmp++; if (stall[1] !== 1'b0) begin n_bad++; $display("FAIL stall_early: got %b expected 0", stall[1]); end end
            if (k == kp + 100) begin n_cmp++; if (stall[1] !== 1'b1) begin n_bad++; $display("FAIL stall_rise: got %b expected 1", stall[1]); end end
        end
        tick_in[1] = 1'b1;
        kp = -1;
        for (int j = 0; j < 8 && kp < 0; j++) begin
            step();
            n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL stall_clear_model k=%0d: got %b expected %b", k, stall, exp_stall); end
            if (tick_en[1] === 1'b1) begin
                kp = k;
                n_cmp++; if (stall[1] !== 1'b0) begin n_bad++; $display("FAIL stall_clear: got %b expected 0", stall[1]); end
            end
        end
        n_cmp++; if (kp < 0) begin n_bad++; $display("FAIL stall_second_pulse: got none expected pulse within 8"); end
        tick_in[1] = 1'b0;
    endtask

    task automatic test_boundary();
        int kp = -1;
        tick_in[3] = 1'b1;
        for (int j = 0; j < 8 && kp < 0; j++) begin
            step();
            if (tick_en[3] === 1'b1) kp = k;
        end
        n_cmp++; if (kp < 0) begin n_bad++; $display("FAIL bnd_first_pulse: got none expected pulse within 8"); return; end
        tick_in[3] = 1'b0;
        while (k < kp + 97) step();
        tick_in[3] = 1'b1;
        repeat (6) begin
            step();
            n_cmp++; if (stall !== exp_stall || tick_en !== exp_en) begin n_bad++; $display("FAIL bnd_model k=%0d: got %b/%b expected %b/%b", k, stall, tick_en, exp_stall, exp_en); end
            if (k == kp + 100) begin n_cmp++; if (tick_en[3] !== 1'b1 || stall[3] !== 1'b0) begin n_bad++; $display("FAIL bnd_cnt99: got en=%b stall=%b expected en=1 stall=0", tick_en[3], stall[3]); end end
        end
    endtask

    task automatic test_simultaneous();
        int k0;
        tick_in = 4'h0;
        repeat (4) step();
        tick_in = 4'hF;
        k0 = k;
        repeat (4) begin
            step();
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL sim_model k=%0d: got %b expected %b", k, tick_en, exp_en); end
            if (k == k0 + 3) begin n_cmp++; if (tick_en !== 4'b1111) begin n_bad++; $display("FAIL sim_all: got %b expected 1111", tick_en); end end
            if (k == k0 + 4) begin n_cmp++; if (tick_en !== 4'b0000) begin n_bad++; $display("FAIL sim_width: got %b expected 0000", tick_en); end end
        end
    endtask

    task automatic test_saturation();
        int kp = -1;
        sel = 2'd0;
        tick_in[0] = 1'b0;
        repeat (3) step();
        tick_in[0] = 1'b1;
        for (int j = 0; j < 8 && kp < 0; j++) begin
            step();
            if (tick_en[0] === 1'b1) kp = k;
        end
        repeat (300) step();
        tick_in[0] = 1'b0;
        repeat (2) step();
        tick_in[0] = 1'b1;
        kp = -1;
        for (int j = 0; j < 8 && kp < 0; j++) begin
            step();
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL sat_model k=%0d: got %b expected %b", k, tick_en, exp_en); end
            if (tick_en[0] === 1'b1) begin
                kp = k;
`ifdef TICK_PERIOD_CAPTURE_EN
                n_cmp++; if (period !== 8'd255 || period_vld !== 1'b1) begin n_bad++; $display("FAIL sat_period: got %0d/%b expected 255/1", period, period_vld); end
`endif
            end
        end
        n_cmp++; if (kp < 0) begin n_bad++; $display("FAIL sat_pulse: got none expected pulse within 8"); end
    endtask

    task automatic test_random();
        int hold[4];
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 70);
        repeat (400) begin
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    tick_in[c] = ~tick_in[c];
                    hold[c] = $urandom_range(1, 70);
                end
            end
            if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
            step();
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL rnd_tick_en k=%0d: got %b expected %b", k, tick_en, exp_en); end
            n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall k=%0d: got %b expected %b", k, stall, exp_stall); end
`ifdef TICK_PERIOD_CAPTURE_EN
            n_cmp++; if (period !== exp_period || period_vld !== exp_vld) begin n_bad++; $display("FAIL rnd_period k=%0d sel=%0d: got %0d/%b expected %0d/%b", k, sel, period, period_vld, exp_period, exp_vld); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int extra = 0;
        tick_in = 4'h0;
        repeat (4) step();
        tick_in = 4'hF;
        for (int j = 0; j < 8 && !found; j++) begin
            step();
            if (tick_en === 4'hF) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_pulse: got none expected 1111 within 8"); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tick_en !== 4'h0 || stall !== 4'h0) begin n_bad++; $display("FAIL mid_async: got en=%b stall=%b expected 0000/0000", tick_en, stall); end
`ifdef TICK_PERIOD_CAPTURE_EN
        n_cmp++; if (period !== 8'd0 || period_vld !== 1'b0) begin n_bad++; $display("FAIL mid_period: got %0d/%b expected 0/0", period, period_vld); end
`endif
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (tick_en !== 4'h0) extra++;
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL mid_model k=%0d: got %b expected %b", k, tick_en, exp_en); end
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL mid_high_release: got %0d pulse cycles expected 0", extra); end
        tick_in = 4'h0;
        repeat (3) step();
        tick_in = 4'h5;
        found = 0;
        repeat (5) begin
            step();
            if (tick_en === 4'h5) found = 1;
            n_cmp++; if (tick_en !== exp_en) begin n_bad++; $display("FAIL mid_rearm k=%0d: got %b expected %b", k, tick_en, exp_en); end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_rearm_pulse: got none expected 0101"); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_periodic();
        test_stall();
        test_boundary();
        test_simultaneous();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
